// File: rtl/ball_kinematics_pkg.sv
// Shared definitions for the basketball projectile integrator.
// FSM encoding, termination codes and default fixed-point constants.
package ball_kinematics_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLIGHT = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    localparam logic [1:0] DONE_NONE    = 2'd0;
    localparam logic [1:0] DONE_OOB     = 2'd1;
    localparam logic [1:0] DONE_SETTLED = 2'd2;
    localparam logic [1:0] DONE_MAX     = 2'd3;

    // Shared with the shot controller so both agree on the number format.
    localparam int DEF_FRAC_BITS = 8;
    localparam int DEF_GRAVITY   = 64;

endpackage

// File: rtl/ball_kinematics_fx_sat_add.sv
// Signed saturating adder.
// Clamps to the most positive / most negative W-bit value on overflow.
module fx_sat_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

    logic signed [W:0] full;

    // Add one bit wider, then clamp when the top two bits disagree.
    always_comb begin
        full = {a[W-1], a} + {b[W-1], b};
        sum  = full[W-1:0];
        if (full[W] != full[W-1]) begin
            sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/ball_kinematics.sv
// Fixed-point projectile integrator for the shot path.
// Semi-implicit Euler per frame tick with floor bounces and side walls.
module ball_kinematics
    import ball_kinematics_pkg::*;
#(
    parameter int FRAC_BITS    = DEF_FRAC_BITS,
    parameter int X_INT_W      = 10,
    parameter int Y_INT_W      = 10,
    parameter int VEL_W        = 16,
    parameter int GRAVITY      = DEF_GRAVITY,
    parameter int SCREEN_W     = 640,
    parameter int FLOOR_Y      = 440,
    parameter int BOUNCE_SHIFT = 1,
    parameter int MAX_BOUNCES  = 3,
    parameter int VMIN         = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               launch,
    input  logic [X_INT_W-1:0] x0,
    input  logic [Y_INT_W-1:0] y0,
    input  logic [VEL_W-1:0]   vx0,
    input  logic [VEL_W-1:0]   vy0,
    output logic               ready,
    output logic               busy,
    output logic [X_INT_W-1:0] pixel_x,
    output logic [Y_INT_W-1:0] pixel_y,
    output logic               done,
    output logic [1:0]         done_code,
    output logic [1:0]         bounce_cnt
);

    localparam int XW = X_INT_W + 2 + FRAC_BITS;
    localparam int YW = Y_INT_W + 2 + FRAC_BITS;

    localparam logic signed [XW-1:0]    X_LIM   = XW'(SCREEN_W << FRAC_BITS);
    localparam logic signed [XW-1:0]    X_CLAMP = XW'((SCREEN_W - 1) << FRAC_BITS);
    localparam logic signed [YW-1:0]    Y_FLOOR = YW'(FLOOR_Y << FRAC_BITS);
    localparam logic signed [VEL_W-1:0] GRAV    = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0] V_MIN   = VEL_W'(VMIN);
    localparam logic [1:0]              MAXB    = 2'(MAX_BOUNCES);

    state_e state_q, state_d;
    logic signed [XW-1:0]    x_q, x_d;
    logic signed [YW-1:0]    y_q, y_d;
    logic signed [VEL_W-1:0] vx_q, vx_d;
    logic signed [VEL_W-1:0] vy_q, vy_d;
    logic [1:0]              code_q, code_d;
    logic [1:0]              bcnt_q, bcnt_d;

    logic signed [VEL_W-1:0] vy_n;
    logic signed [VEL_W-1:0] vy_half;
    logic signed [XW-1:0]    vx_ext, x_n;
    logic signed [YW-1:0]    vy_ext, y_n;
    logic [1:0]              bcnt_inc;

    assign vx_ext = {{(XW-VEL_W){vx_q[VEL_W-1]}}, vx_q};
    assign vy_ext = {{(YW-VEL_W){vy_n[VEL_W-1]}}, vy_n};

    fx_sat_add #(.W(VEL_W)) u_vy_add (.a(vy_q), .b(GRAV),   .sum(vy_n));
    fx_sat_add #(.W(XW))    u_x_add  (.a(x_q),  .b(vx_ext), .sum(x_n));
    fx_sat_add #(.W(YW))    u_y_add  (.a(y_q),  .b(vy_ext), .sum(y_n));

    assign vy_half  = vy_n >>> BOUNCE_SHIFT;
    assign bcnt_inc = (bcnt_q == 2'd3) ? 2'd3 : bcnt_q + 2'd1;

    // Next-state: launch capture, per-tick integration, floor and wall handling.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        code_d  = code_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    x_d     = {2'b00, x0, {FRAC_BITS{1'b0}}};
                    y_d     = {2'b00, y0, {FRAC_BITS{1'b0}}};
                    vx_d    = vx0;
                    vy_d    = vy0;
                    bcnt_d  = 2'd0;
                    code_d  = DONE_NONE;
                    state_d = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (frame_tick) begin
                    vy_d = vy_n;
                    x_d  = x_n;
                    y_d  = y_n;
                    if (x_n[XW-1]) begin
                        x_d    = '0;
                        code_d = DONE_OOB;
                    end else if (x_n >= X_LIM) begin
                        x_d    = X_CLAMP;
                        code_d = DONE_OOB;
                    end else if (y_n >= Y_FLOOR && !vy_n[VEL_W-1] && vy_n != '0) begin
                        y_d    = Y_FLOOR;
                        vy_d   = -vy_half;
                        bcnt_d = bcnt_inc;
                        if (bcnt_inc == MAXB) begin
                            code_d = DONE_MAX;
                        end else if (vy_half < V_MIN) begin
                            code_d = DONE_SETTLED;
                        end
                    end
                    if (code_d != DONE_NONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and kinematic registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            code_q  <= DONE_NONE;
            bcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            code_q  <= code_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign busy       = (state_q == S_FLIGHT);
    assign done       = (state_q == S_DONE);
    assign done_code  = code_q;
    assign bounce_cnt = bcnt_q;
    assign pixel_x    = x_q[FRAC_BITS +: X_INT_W];
    assign pixel_y    = y_q[YW-1] ? '0 : y_q[FRAC_BITS +: Y_INT_W];

endmodule

// File: tb/tb_ball_kinematics.sv
// Scoreboard bench for ball_kinematics.
// Reference model integrates the trajectory with plain integer arithmetic.
module tb_ball_kinematics;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        launch = 1'b0;
    logic [9:0]  x0 = '0;
    logic [9:0]  y0 = '0;
    logic [15:0] vx0 = '0;
    logic [15:0] vy0 = '0;
    logic        ready, busy, done;
    logic [9:0]  pixel_x, pixel_y;
    logic [1:0]  done_code, bounce_cnt;

    always #5 clk = ~clk;

    ball_kinematics dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .launch(launch),
        .x0(x0), .y0(y0), .vx0(vx0), .vy0(vy0),
        .ready(ready), .busy(busy), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .done(done), .done_code(done_code), .bounce_cnt(bounce_cnt)
    );

    typedef struct {
        int px; int py; int bc; int dc; int rdy; int bsy; int dn;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: positions and velocities in 1/256 pixel units.
    int mx, my, mvx, mvy, mbc, mdc, mmode;  // mmode 0 idle, 1 flight, 2 done
    logic rst_pulse = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.px  = (mx / 256) % 1024;
        e.py  = (my < 0) ? 0 : (my / 256) % 1024;
        e.bc  = mbc;
        e.dc  = mdc;
        e.rdy = (mmode == 0);
        e.bsy = (mmode == 1);
        e.dn  = (mmode == 2);
        return e;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mvx = 0; mvy = 0; mbc = 0; mdc = 0; mmode = 0;
    endtask

    task automatic model_tick();
        int xn, yn, mag;
        mvy = clampi(mvy + 64, -32768, 32767);
        xn  = clampi(mx + mvx, -(1 << 19), (1 << 19) - 1);
        yn  = clampi(my + mvy, -(1 << 19), (1 << 19) - 1);
        if (xn < 0) begin
            mx = 0; my = yn; mdc = 1;
        end else if (xn >= 640 * 256) begin
            mx = 639 * 256; my = yn; mdc = 1;
        end else begin
            mx = xn;
            if (yn >= 440 * 256 && mvy > 0) begin
                my  = 440 * 256;
                mag = mvy / 2;
                mvy = -mag;
                mbc = (mbc < 3) ? mbc + 1 : 3;
                if (mbc == 3) mdc = 3;
                else if (mag < 128) mdc = 2;
            end else begin
                my = yn;
            end
        end
        if (mdc != 0) mmode = 2;
    endtask

    // One stimulus event: model predicts, expectation queued, inputs pulsed for a cycle.
    task automatic do_event(input bit l, input bit t, input int xv, input int yv,
                            input int vxv, input int vyv);
        @(posedge clk);
        #1;
        if (mmode == 2) mmode = 0;
        if (l && mmode == 0) begin
            mx = xv * 256; my = yv * 256; mvx = vxv; mvy = vyv;
            mbc = 0; mdc = 0; mmode = 1;
        end else if (t && mmode == 1) begin
            model_tick();
        end
        q.push_back(model_out());
        launch     = l;
        frame_tick = t;
        x0  = 10'(xv);
        y0  = 10'(yv);
        vx0 = 16'(vxv);
        vy0 = 16'(vyv);
        @(posedge clk);
        #1;
        launch     = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        model_reset();
        q.push_back(model_out());
        rst_n     = 1'b0;
        rst_pulse = 1'b1;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rst_pulse = 1'b0;
    endtask

    task automatic tick();
        do_event(1'b0, 1'b1, int'($urandom_range(0, 639)), int'($urandom_range(0, 439)),
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 4095)));
    endtask

    // Launch then tick until the model says the flight ended (bounded).
    task automatic run_flight(input int xv, input int yv, input int vxv, input int vyv,
                              input int max_ticks, input bit noisy);
        do_event(1'b1, 1'b0, xv, yv, vxv, vyv);
        for (int i = 0; i < max_ticks && mmode == 1; i++) begin
            if (noisy && $urandom_range(0, 7) == 0)
                do_event(1'b1, 1'b0, int'($urandom_range(0, 639)), int'($urandom_range(0, 439)),
                         int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
            if (noisy && $urandom_range(0, 7) == 0)
                do_event(1'b1, 1'b1, 5, 5, 100, 100);
            else
                tick();
        end
    endtask

    // Monitor: every cycle where stimulus was applied gets compared one edge later.
    logic evt = 1'b0;
    logic post_done = 1'b0;

    always @(posedge clk) evt <= launch | frame_tick | rst_pulse;

    always @(negedge clk) begin
        exp_t e;
        if (post_done) begin
            post_done <= 1'b0;
            check("done_width", int'(done), 0);
            check("ready_after_done", int'(ready), 1);
        end
        if (evt) begin
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: output with no expectation at %0t", $time);
            end else begin
                e = q.pop_front();
                check("pixel_x", int'(pixel_x), e.px);
                check("pixel_y", int'(pixel_y), e.py);
                check("bounce_cnt", int'(bounce_cnt), e.bc);
                check("done_code", int'(done_code), e.dc);
                check("ready", int'(ready), e.rdy);
                check("busy", int'(busy), e.bsy);
                check("done", int'(done), e.dn);
                if (e.dn != 0) post_done <= 1'b1;
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pixel_x", int'(pixel_x), 0);
        check("rst_pixel_y", int'(pixel_y), 0);
        check("rst_done_code", int'(done_code), 0);
        check("rst_bounce_cnt", int'(bounce_cnt), 0);
        rst_n = 1'b1;

        // Upward launch through the apex, then reset mid-flight.
        do_event(1'b1, 1'b1, 10, 400, 'h200, -'h800);
        for (int i = 0; i < 34; i++) tick();
        do_event(1'b1, 1'b0, 50, 50, 'h100, 'h100);
        tick();
        do_reset();
        tick();

        // Floor bounce, wall hits both sides, settle, bounce-count limit.
        run_flight(100, 439, 0, 'h400, 400, 1'b0);
        run_flight(638, 200, 'h300, 0, 400, 1'b0);
        run_flight(1, 200, -'h200, 0, 400, 1'b0);
        run_flight(100, 439, 0, 'h100, 400, 1'b0);
        run_flight(300, 0, 0, 0, 400, 1'b0);
        run_flight(20, 430, 'h0C0, -'h300, 400, 1'b0);

        // Randomised flights with stray launches during flight.
        for (int n = 0; n < 15; n++) begin
            run_flight(int'($urandom_range(0, 639)), int'($urandom_range(0, 439)),
                       int'($urandom_range(0, 2048)) - 1024,
                       int'($urandom_range(0, 4096)) - 3072, 400, 1'b1);
            if (mmode == 1) do_reset();
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
